// File: rtl/trng_pkg.sv
// trng_pkg: shared collector state encoding and default mux-tree sizing
package trng_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, PUSH} collector_state_e;
    localparam int TRNG_N_SRC = 8;
    localparam int TRNG_SEL_W = 3;
endpackage

// File: rtl/trng_sync_2ff.sv
// trng_sync_2ff: two-flop synchronizer for the asynchronous entropy bit
module trng_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta;
    always_ff @(posedge clk_i) begin
        if (rst_i) {q_o, meta} <= 2'b00;
        else       {q_o, meta} <= {meta, d_i};
    end
endmodule

// File: rtl/trng_bit_collector.sv
// trng_bit_collector: round-robin entropy sampler packing bits into words on valid/ready
// optional von Neumann debiasing with TRNG_COLLECTOR_VN_DEBIAS_EN
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int N_SRC         = TRNG_N_SRC,
    parameter int SEL_W         = TRNG_SEL_W,
    parameter int WORD_W        = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              entropy_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o
);
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam int BW = $clog2(WORD_W);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);
    collector_state_e state, state_next;
    logic [CW-1:0] settle_cnt;
    logic [BW-1:0] bit_cnt;
    logic [WORD_W-2:0] word;
    logic [WORD_W-1:0] shifted;
    logic sync_bit, sample_bit, take, drop, advance, keep, word_done;
    trng_sync_2ff u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (entropy_i),
        .q_o  (sync_bit)
    );
    assign take = state == SAMPLE && enable_i;
    assign drop = !enable_i && (state == SETTLE || state == SAMPLE);
`ifdef TRNG_COLLECTOR_VN_DEBIAS_EN
    logic phase, first_bit;
    // pair (a, b): only the second sample of a pair may keep a bit or move the mux
    assign advance    = take && phase;
    assign keep       = advance && first_bit != sync_bit;
    assign sample_bit = first_bit;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase     <= 1'b0;
            first_bit <= 1'b0;
        end else if (drop) begin
            phase <= 1'b0;
        end else if (take) begin
            phase <= !phase;
            if (!phase) first_bit <= sync_bit;
        end
    end
`else
    assign advance    = take;
    assign keep       = take;
    assign sample_bit = sync_bit;
`endif
    assign word_done = keep && bit_cnt == BIT_LAST;
    assign shifted   = {word, sample_bit};
    assign valid_o   = state == PUSH;
    assign busy_o    = state != IDLE;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = enable_i ? SETTLE : IDLE;
            SETTLE:  state_next = !enable_i ? IDLE : settle_cnt == SETTLE_LAST ? SAMPLE : SETTLE;
            SAMPLE:  state_next = !enable_i ? IDLE : word_done ? PUSH : SETTLE;
            PUSH:    state_next = !ready_i ? PUSH : enable_i ? SETTLE : IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            data_o     <= '0;
            sel_o      <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
            if (keep) word <= shifted[WORD_W-2:0];
            if (drop || word_done) bit_cnt <= '0;
            else if (keep) bit_cnt <= bit_cnt + 1'b1;
            if (advance) sel_o <= sel_o == SEL_LAST ? '0 : sel_o + 1'b1;
            if (word_done) data_o <= shifted;
        end
    end
endmodule

// File: tb/tb_trng_bit_collector.sv
// tb_trng_bit_collector: directed stimulus with a word scoreboard checked at each transfer
module tb_trng_bit_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ready = 1'b0;
    logic mode = 1'b0;
    logic const_bit = 1'b1;
    logic entropy;
    logic [2:0] sel;
    logic [31:0] data;
    logic valid, busy;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int n, m, err, changes;
    logic [2:0] prev, s0;
    logic [31:0] d;

    trng_bit_collector dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .entropy_i(entropy),
        .sel_o    (sel),
        .data_o   (data),
        .valid_o  (valid),
        .ready_i  (ready),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;
    // mode 1 models the mux: source k emits bit k[0]
    always_comb entropy = mode ? sel[0] : const_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cnt);
        cnt = 0;
        while (!valid && cnt < max) begin
            step();
            cnt++;
        end
        check("valid_seen", {31'd0, valid}, 32'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (valid && ready) begin
                if (exp_q.size() != 0) check("word", data, exp_q.pop_front());
                else check("scoreboard_has_entry", 32'(exp_q.size()), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();
`ifdef TRNG_COLLECTOR_VN_DEBIAS_EN
        mode = 1'b0; const_bit = 1'b1; ready = 1'b1; enable = 1'b1;
        err = 0;
        repeat (1000) begin
            step();
            if (valid) err++;
        end
        check("vn_const_no_valid", err, 0);
        enable = 1'b0;
        repeat (2) step();
        exp_q.push_back(32'hFFFF_FFFF);
        m = 0;
        const_bit = 1'b0;
        enable = 1'b1;
        while (!valid && m < 800) begin
            step();
            m++;
            const_bit = ((m + 2) / 5) % 2 == 1;
        end
        check("vn_toggle_valid", {31'd0, valid}, 32'd1);
        enable = 1'b0;
        step();
        check("vn_idle", {31'd0, busy}, 32'd0);
`else
        mode = 1'b0; const_bit = 1'b1; ready = 1'b1; enable = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        step();
        check("busy_after_enable", {31'd0, busy}, 32'd1);
        n = 0; prev = sel; err = 0; changes = 0;
        while (!valid && n < 400) begin
            step();
            n++;
            if (sel != prev) begin
                s0 = prev + 3'd1;
                if (sel != s0) err++;
                changes++;
                prev = sel;
            end
        end
        check("word_latency", n, 160);
        check("sel_order_errors", err, 0);
        check("sel_changes", changes, 32);
        enable = 1'b0;
        step();
        check("a_valid_drop", {31'd0, valid}, 32'd0);
        check("a_idle", {31'd0, busy}, 32'd0);
        check("a_data_hold", data, 32'hFFFF_FFFF);
        check("a_sel_wrap", {29'd0, sel}, 32'd0);

        mode = 1'b1;
        exp_q.push_back(32'h5555_5555);
        exp_q.push_back(32'h5555_5555);
        enable = 1'b1;
        step();
        wait_valid(400, n);
        step();
        check("b_valid_drop", {31'd0, valid}, 32'd0);
        wait_valid(400, n);
        enable = 1'b0;
        step();
        check("b_idle", {31'd0, busy}, 32'd0);

        ready = 1'b0;
        exp_q.push_back(32'h5555_5555);
        enable = 1'b1;
        step();
        wait_valid(400, n);
        d = data; s0 = sel; err = 0;
        repeat (50) begin
            step();
            if (!valid || data != d || sel != s0) err++;
        end
        check("stall_stable", err, 0);
        ready = 1'b1;
        enable = 1'b0;
        step();
        check("stall_valid_drop", {31'd0, valid}, 32'd0);
        check("stall_idle", {31'd0, busy}, 32'd0);

        enable = 1'b1;
        s0 = sel; prev = sel; changes = 0; n = 0;
        while (changes < 10 && n < 200) begin
            step();
            n++;
            if (sel != prev) begin
                changes++;
                prev = sel;
            end
        end
        enable = 1'b0;
        step();
        check("drop_idle", {31'd0, busy}, 32'd0);
        s0 = s0 + 3'd2;
        check("drop_sel", {29'd0, sel}, {29'd0, s0});
        err = 0;
        repeat (20) begin
            step();
            if (valid || busy) err++;
        end
        check("drop_quiet", err, 0);
        exp_q.push_back(32'h5555_5555);
        enable = 1'b1;
        step();
        wait_valid(400, n);
        check("fresh_word_latency", n, 160);
        enable = 1'b0;
        step();

        ready = 1'b0; mode = 1'b0; const_bit = 1'b1; enable = 1'b1;
        step();
        wait_valid(400, n);
        rst = 1'b1;
        step();
        check("rst_push_valid", {31'd0, valid}, 32'd0);
        check("rst_push_sel", {29'd0, sel}, 32'd0);
        check("rst_push_data", data, 32'd0);
        check("rst_push_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        step();
`endif
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trng_bit_collector.md
Name: trng_bit_collector

Overview:
- Consumer side of the TRNG source-select mux tree.
- Drives the select lines of the 8:1 ring-oscillator mux (mux_8to1, built from mux_4to1/mux_2to1), waits a settle interval after each select change, then samples the muxed entropy bit through a 2-flop synchronizer.
- Packs samples into WORD_W-bit words and presents each word downstream on a valid/ready handshake.

Parameters:
- N_SRC, 8: number of selectable entropy sources; legal range 2..2^SEL_W.
- SEL_W, 3: width of sel_o; must satisfy 2^SEL_W >= N_SRC.
- WORD_W, 32: bits per output word; minimum 2.
- SETTLE_CYCLES, 4: clk_i cycles from a sel_o change to the sample point; minimum 3, which covers the synchronizer depth.

Ports:
- clk_i, input, 1: sole clock.
- rst_i, input, 1: reset; synchronous, active-high.
- enable_i, input, 1: run request.
- entropy_i, input, 1: raw mux output; asynchronous to clk_i.
- sel_o, output, SEL_W: mux select.
- data_o, output, WORD_W: collected word.
- valid_o, output, 1: data_o is valid.
- ready_i, input, 1: downstream accepts the word.
- busy_o, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; applies at any time, including mid-word or mid-handshake):
  - Outputs: sel_o=0, data_o=0, valid_o=0, busy_o=0.
  - Internal: state=IDLE, bit count=0, settle counter=0, synchronizer flops=0.
- Synchronizer: entropy_i passes through 2 flops; only the second flop output (sync_bit) is ever used.
- FSM states: IDLE, SETTLE, SAMPLE, PUSH.
- IDLE:
  - enable_i=1 -> SETTLE, settle counter cleared.
  - sel_o holds its last value.
- SETTLE:
  - Settle counter increments each cycle.
  - When counter == SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (exactly 1 cycle):
  - Shift register updates as word <= {word[WORD_W-2:0], sync_bit}; the first-sampled bit ends up in the MSB.
  - Bit count increments.
  - sel_o advances round-robin: sel_o <= (sel_o == N_SRC-1) ? 0 : sel_o+1.
  - If bit count reaches WORD_W -> PUSH; otherwise -> SETTLE with counter cleared.
- PUSH:
  - data_o is loaded with the word and valid_o=1.
  - data_o must stay stable while valid_o=1 and ready_i=0.
  - A transfer occurs on any cycle with valid_o=1 and ready_i=1. On transfer: valid_o<=0, bit count<=0, then -> SETTLE if enable_i=1, else -> IDLE.
  - valid_o never depends combinationally on ready_i.
  - The sel_o value from the last SAMPLE is held throughout PUSH.
- Sample spacing: one sample every SETTLE_CYCLES+1 cycles. With defaults, a full word (no stall) takes 32*5 = 160 cycles from leaving IDLE until valid_o rises.
- enable_i deasserted in SETTLE or SAMPLE: -> IDLE next cycle; the partial word and bit count are discarded and no sample is taken that cycle.
- enable_i deasserted in PUSH: the pending word is still delivered, then -> IDLE.
- data_o holds the last transferred word until the next PUSH load.

Optional Feature:
- Macro: TRNG_COLLECTOR_VN_DEBIAS_EN.
- When defined, von Neumann debiasing is applied:
  - Each source is sampled twice in succession (a, then b). sel_o advances only after the second sample of the pair.
  - If a != b, bit a is shifted in and bit count increments.
  - If a == b, the pair is discarded and bit count is unchanged.
  - A 1-bit pair-phase flop is added; it resets to 0 and clears on enable_i drop.
- When undefined: every SAMPLE shifts one bit, as described above; no extra state exists.

Decomposition:
- Package trng_pkg holds:
  - collector_state_e (IDLE/SETTLE/SAMPLE/PUSH, 2-bit enum);
  - default constants TRNG_N_SRC=8, TRNG_SEL_W=3.
- One sub-module, trng_sync_2ff: 2-flop synchronizer, ports clk_i, rst_i, d_i, q_o, sync reset to 0.

Test Plan:
- Reset then enable_i=1 with entropy_i tied to 1, ready_i=1 -> valid_o rises 160 cycles after IDLE exit; data_o=32'hFFFF_FFFF; sel_o sequence 0,1,...,7,0 repeating.
- entropy_i driven to equal sel_o[0] (bench model of mux) -> data_o=32'h5555_5555; second word identical.
- ready_i held 0 for 50 cycles after valid_o -> data_o and valid_o stable, sel_o frozen; accepted on the cycle ready_i=1, valid_o=0 next cycle.
- enable_i dropped after 10 samples -> IDLE within 1 cycle, busy_o=0, no valid_o; re-enable produces a full fresh 32-bit word (no leftover bits).
- rst_i asserted mid-PUSH with valid_o=1 -> next cycle valid_o=0, sel_o=0, data_o=0, busy_o=0.
- With TRNG_COLLECTOR_VN_DEBIAS_EN: entropy_i constant 1 -> valid_o never asserts over 1000 cycles; entropy_i toggling every sample -> bit a of each pair is 1, data_o=32'hFFFF_FFFF after 64 samples.
